// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Brief    : MEM-stage data memory with configurable wait states, pipeline
//            stall, RV32I load/store sizing, extension and error detection.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          c_IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_BYTES     = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  c_WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic [1:0]  r_state;
    logic [3:0]  r_wcnt;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [1:0]         w_state_nxt;
    logic [3:0]         w_wcnt_nxt;
    logic               w_capture;
    logic               w_enter_resp;
    logic               w_write;
    logic [1:0]         w_size;
    logic               w_unsigned;
    logic [31:0]        w_addr;
    logic [31:0]        w_wdata;
    logic               w_err;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;
    logic [3:0]         w_be;
    logic [31:0]        w_lane;

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_wcnt_nxt  = c_WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                // Requester withdrew: abandon the access without side effects
                if (!req_valid) begin
                    w_state_nxt = S_IDLE;
                    w_wcnt_nxt  = 4'd0;
                end else if (r_wcnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_wcnt_nxt = r_wcnt - 4'd1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);

    // With zero wait states the access happens on the accept edge, before capture
    assign w_write    = (r_state == S_IDLE) ? req_write    : r_write;
    assign w_size     = (r_state == S_IDLE) ? req_size     : r_size;
    assign w_unsigned = (r_state == S_IDLE) ? req_unsigned : r_unsigned;
    assign w_addr     = (r_state == S_IDLE) ? req_addr     : r_addr;
    assign w_wdata    = (r_state == S_IDLE) ? req_wdata    : r_wdata;

    always_comb begin
        w_err = (w_addr >= c_BYTES);
        case (w_size)
            2'b01:   w_err = w_err | w_addr[0];
            2'b10:   w_err = w_err | (w_addr[1:0] != 2'b00);
            2'b11:   w_err = 1'b1;
            default: w_err = w_err;
        endcase
    end

    assign w_idx  = w_addr[c_IDX_W+1:2];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
    assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = w_word;
        w_be   = 4'b1111;
        w_lane = w_wdata;
        case (w_size)
            2'b00: begin
                w_load = w_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
                w_be   = 4'b0001 << w_addr[1:0];
                w_lane = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_load = w_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
                w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
                w_lane = {2{w_wdata[15:0]}};
            end
            default: begin
                w_load = w_word;
                w_be   = 4'b1111;
                w_lane = w_wdata;
            end
        endcase
    end

    // Array carries no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (w_enter_resp && !reset && w_write && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_lane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wcnt     <= 4'd0;
            r_write    <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_capture) begin
                r_write    <= req_write;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
            end
            r_rdata <= (w_enter_resp && !w_err && !w_write) ? w_load : 32'd0;
            r_err   <= w_enter_resp && w_err;
        end
    end

    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_stall  = req_valid && (r_state != S_RESP) && !reset;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Directed self-checking bench for data_mem_responder with
//            WAIT_CYCLES of 1, 0 and 3.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall [3];
    logic        rv    [3];
    logic        err   [3];
    logic [31:0] rdata [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // index 0: WAIT_CYCLES=1, index 1: WAIT_CYCLES=0, index 2: WAIT_CYCLES=3
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .mem_stall(stall[0]), .resp_valid(rv[0]),
        .resp_rdata(rdata[0]), .resp_err(err[0])
    );
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .mem_stall(stall[1]), .resp_valid(rv[1]),
        .resp_rdata(rdata[1]), .resp_err(err[1])
    );
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .mem_stall(stall[2]), .resp_valid(rv[2]),
        .resp_rdata(rdata[2]), .resp_err(err[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request, counts stalled cycles until resp_valid, then releases it
    task automatic access(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int nstall);
        bit done;
        done   = 1'b0;
        rd     = 32'd0;
        er     = 1'b0;
        nstall = 0;
        @(negedge clk);
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid[d] = 1'b1;
        #1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (rv[d]) begin
                done = 1'b1;
                rd   = rdata[d];
                er   = err[d];
                check("stall_low_in_resp", 32'(stall[d]), 32'd0);
            end else begin
                if (stall[d]) nstall++;
                @(negedge clk);
                #1;
            end
        end
        check("resp_seen", 32'(done), 32'd1);
        req_valid[d] = 1'b0;
        @(negedge clk);
        #1;
        check("resp_one_cycle", 32'(rv[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          ns;

        reset        = 1'b1;
        req_valid    = 3'b000;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        repeat (2) @(negedge clk);
        req_valid[0] = 1'b1;
        #1;
        check("stall_in_reset", 32'(stall[0]), 32'd0);
        check("reset_valid", 32'(rv[0]), 32'd0);
        check("reset_rdata", rdata[0], 32'd0);
        check("reset_err", 32'(err[0]), 32'd0);
        req_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Word store then load, WAIT_CYCLES=1
        access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, ns);
        check("sw_err", 32'(er), 32'd0);
        check("sw_rdata", rd, 32'd0);
        check("sw_stall_len", 32'(ns), 32'd2);
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er, ns);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err", 32'(er), 32'd0);
        check("lw_stall_len", 32'(ns), 32'd2);

        // Byte store, then sized loads
        access(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h12345680, rd, er, ns);
        check("sb_err", 32'(er), 32'd0);
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er, ns);
        check("lw_after_sb", rd, 32'hDEAD80EF);
        access(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'd0, rd, er, ns);
        check("lb_sign", rd, 32'hFFFFFF80);
        access(0, 1'b0, 2'b00, 1'b1, 32'h11, 32'd0, rd, er, ns);
        check("lbu_zero", rd, 32'h00000080);
        access(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, rd, er, ns);
        check("lh_sign", rd, 32'hFFFFDEAD);
        access(0, 1'b0, 2'b01, 1'b1, 32'h10, 32'd0, rd, er, ns);
        check("lhu_zero", rd, 32'h000080EF);
        access(0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234, rd, er, ns);
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er, ns);
        check("lw_after_sh", rd, 32'h123480EF);

        // Error cases
        access(0, 1'b0, 2'b10, 1'b0, 32'h12, 32'd0, rd, er, ns);
        check("lw_mis_err", 32'(er), 32'd1);
        check("lw_mis_rdata", rd, 32'd0);
        check("lw_mis_stall_len", 32'(ns), 32'd2);
        access(0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h55555555, rd, er, ns);
        check("sw_mis_err", 32'(er), 32'd1);
        access(0, 1'b0, 2'b01, 1'b0, 32'h11, 32'd0, rd, er, ns);
        check("lh_odd_err", 32'(er), 32'd1);
        access(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, rd, er, ns);
        check("size11_err", 32'(er), 32'd1);
        check("size11_rdata", rd, 32'd0);
        access(0, 1'b1, 2'b10, 1'b0, 32'h400, 32'h77777777, rd, er, ns);
        check("sw_oor_err", 32'(er), 32'd1);
        access(0, 1'b1, 2'b10, 1'b0, 32'h3FC, 32'hA5A55A5A, rd, er, ns);
        check("sw_last_err", 32'(er), 32'd0);
        access(0, 1'b0, 2'b10, 1'b0, 32'h3FC, 32'd0, rd, er, ns);
        check("lw_last", rd, 32'hA5A55A5A);
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er, ns);
        check("lw_after_errs", rd, 32'h123480EF);

        // Zero and three wait states
        access(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, rd, er, ns);
        check("w0_sw_stall_len", 32'(ns), 32'd1);
        access(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, rd, er, ns);
        check("w0_lw_rdata", rd, 32'hCAFEF00D);
        check("w0_lw_stall_len", 32'(ns), 32'd1);
        access(1, 1'b0, 2'b00, 1'b0, 32'h43, 32'd0, rd, er, ns);
        check("w0_lb_rdata", rd, 32'hFFFFFFCA);
        access(2, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0BADC0DE, rd, er, ns);
        check("w3_sw_stall_len", 32'(ns), 32'd4);
        access(2, 1'b0, 2'b01, 1'b1, 32'h42, 32'd0, rd, er, ns);
        check("w3_lhu_rdata", rd, 32'h00000BAD);
        check("w3_lhu_stall_len", 32'(ns), 32'd4);

        // Reset while a store waits
        access(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111, rd, er, ns);
        @(negedge clk);
        req_write    = 1'b1;
        req_size     = 2'b10;
        req_addr     = 32'h20;
        req_wdata    = 32'h22222222;
        req_valid[0] = 1'b1;
        @(negedge clk);
        #1;
        check("stall_in_wait", 32'(stall[0]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid_valid", 32'(rv[0]), 32'd0);
        check("rst_mid_rdata", rdata[0], 32'd0);
        check("rst_mid_err", 32'(err[0]), 32'd0);
        check("rst_mid_stall", 32'(stall[0]), 32'd0);
        req_valid[0] = 1'b0;
        reset        = 1'b0;
        access(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, rd, er, ns);
        check("lw_after_rst", rd, 32'h11111111);

        // Abort a store by dropping req_valid in WAIT
        @(negedge clk);
        req_write    = 1'b1;
        req_size     = 2'b10;
        req_addr     = 32'h10;
        req_wdata    = 32'hFFFFFFFF;
        req_valid[0] = 1'b1;
        @(negedge clk);
        #1;
        check("abort_in_wait", 32'(stall[0]), 32'd1);
        req_valid[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("abort_no_resp", 32'(rv[0]), 32'd0);
        end
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er, ns);
        check("lw_after_abort", rd, 32'h123480EF);
        check("lw_after_abort_stall", 32'(ns), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
